// File: rtl/instr_fetch_decode.sv
// ---------------------------------------------------------------------------
// instr_fetch_decode
//
// Purpose: fetches 16-bit instructions from memory, latches them into the
// instruction register (IR) and drives the decoded fields. Instructions with
// opcode 101 or 110 start the downstream controller with a one-cycle pulse on s.
// The fetch unit then waits for ctrl_done before it fetches again. Any other
// opcode is skipped and reported with a one-cycle pulse on bad_instr.
//
// Optional feature: when the macro INSTR_FETCH_HALT_EN is defined, opcode 111
// parks the unit in SHALT until reset. When the macro is undefined, opcode 111
// is skipped like any other undecodable opcode and halted is tied low.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   mem_req, mem_addr    instruction read request / address (= pc)
//   mem_ack, mem_rdata   read accepted / instruction word (same cycle)
//   s                    one-cycle start pulse to the controller
//   ctrl_done            controller finished; only honoured in SWAIT
//   opcode, op, ALUop,
//   shift                decoded IR fields
//   nsel                 one-hot register select (001 Rn, 010 Rd, 100 Rm)
//   readnum, writenum    selected register field (000 if nsel not one-hot)
//   sximm8, sximm5       sign-extended immediates
//   bad_instr            one-cycle pulse when an instruction was skipped
//   halted               high while in SHALT
//   pc                   current program counter
//   dbg_state_o          current FSM state, for observation
//
// Memory handshake: mem_req is the valid and mem_ack is the ready. A read
// transfers on the rising edge where both are high. mem_rdata is sampled on
// that same edge. mem_req and mem_addr stay stable until the transfer
// happens. mem_ack is ignored while mem_req is low.
// ---------------------------------------------------------------------------
module instr_fetch_decode #(
    parameter int unsigned         PC_W     = 8,
    parameter logic [PC_W-1:0]     RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            mem_req,
    output logic [PC_W-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [15:0]     mem_rdata,
    output logic            s,
    input  logic            ctrl_done,
    output logic [2:0]      opcode,
    output logic [1:0]      op,
    output logic [1:0]      ALUop,
    output logic [1:0]      shift,
    input  logic [2:0]      nsel,
    output logic [2:0]      readnum,
    output logic [2:0]      writenum,
    output logic [15:0]     sximm8,
    output logic [15:0]     sximm5,
    output logic            bad_instr,
    output logic            halted,
    output logic [PC_W-1:0] pc,
    output logic [1:0]      dbg_state_o
);

    typedef enum logic [1:0] {
        SFETCH = 2'd0,
        SSTART = 2'd1,
        SWAIT  = 2'd2,
        SHALT  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic            bad_q, bad_d;
    logic [2:0]      regnum;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SFETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            bad_q   <= bad_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        bad_d   = 1'b0;
        unique case (state_q)
            SFETCH: begin
                if (mem_ack) begin
                    ir_d = mem_rdata;
                    // The adder has the same width as pc, so an all-ones pc wraps to zero.
                    pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
                    unique case (mem_rdata[15:13])
                        3'b101, 3'b110: state_d = SSTART;
                        3'b111: begin
`ifdef INSTR_FETCH_HALT_EN
                            state_d = SHALT;
`else
                            bad_d   = 1'b1;
`endif
                        end
                        default: bad_d = 1'b1;
                    endcase
                end
            end
            SSTART: state_d = SWAIT;
            SWAIT:  if (ctrl_done) state_d = SFETCH;
            SHALT:  state_d = SHALT;
            default: state_d = SFETCH;
        endcase
    end

    // Moore outputs: each one depends only on registered state.
    assign mem_req     = (state_q == SFETCH);
    assign mem_addr    = pc_q;
    assign s           = (state_q == SSTART);
    assign bad_instr   = bad_q;
    assign pc          = pc_q;
    assign dbg_state_o = state_q;

`ifdef INSTR_FETCH_HALT_EN
    assign halted = (state_q == SHALT);
`else
    assign halted = 1'b0;
`endif

    // Decode works directly on IR. IR changes only when a fetch is accepted.
    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign ALUop  = ir_q[12:11];
    assign shift  = ir_q[4:3];
    assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
    assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};

    always_comb begin
        unique case (nsel)
            3'b001:  regnum = ir_q[10:8];
            3'b010:  regnum = ir_q[7:5];
            3'b100:  regnum = ir_q[2:0];
            default: regnum = 3'b000;
        endcase
    end

    assign readnum  = regnum;
    assign writenum = regnum;

endmodule

// File: tb/tb_instr_fetch_decode.sv
module tb_instr_fetch_decode;

  logic        clk = 1'b0;
  logic        reset, mem_ack, ctrl_done;
  logic [15:0] mem_rdata;
  logic [2:0]  nsel;
  logic        mem_req, s, bad_instr, halted;
  logic [7:0]  mem_addr, pc;
  logic [2:0]  opcode, readnum, writenum;
  logic [1:0]  op, alu_op, shift, dbg_state;
  logic [15:0] sximm8, sximm5;

  // second instance: RESET_PC = 8'hFF for the wrap-around case
  logic        reset2, mem_ack2;
  logic [15:0] mem_rdata2;
  logic        mem_req2, s2, bad2, halted2;
  logic [7:0]  mem_addr2, pc2;
  logic [2:0]  opcode2, readnum2, writenum2;
  logic [1:0]  op2, alu_op2, shift2, dbg_state2;
  logic [15:0] sximm8_2, sximm5_2;

  int n_cmp = 0;
  int n_err = 0;

  instr_fetch_decode #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .s(s), .ctrl_done(ctrl_done),
    .opcode(opcode), .op(op), .ALUop(alu_op), .shift(shift), .nsel(nsel),
    .readnum(readnum), .writenum(writenum), .sximm8(sximm8), .sximm5(sximm5),
    .bad_instr(bad_instr), .halted(halted), .pc(pc), .dbg_state_o(dbg_state)
  );

  instr_fetch_decode #(.PC_W(8), .RESET_PC(8'hFF)) dut_ff (
    .clk(clk), .reset(reset2), .mem_req(mem_req2), .mem_addr(mem_addr2),
    .mem_ack(mem_ack2), .mem_rdata(mem_rdata2), .s(s2), .ctrl_done(1'b0),
    .opcode(opcode2), .op(op2), .ALUop(alu_op2), .shift(shift2), .nsel(3'b001),
    .readnum(readnum2), .writenum(writenum2), .sximm8(sximm8_2), .sximm5(sximm5_2),
    .bad_instr(bad2), .halted(halted2), .pc(pc2), .dbg_state_o(dbg_state2)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge; sample and drive 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_ack = 1'b0; ctrl_done = 1'b0; mem_rdata = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    nsel = 3'b001;
    reset2 = 1'b0; mem_ack2 = 1'b0; mem_rdata2 = '0;
    do_reset();
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL reset_mem_req got %b exp 1", mem_req); end
    n_cmp++; if (pc !== 8'h00) begin n_err++; $display("FAIL reset_pc got %h exp 00", pc); end
    n_cmp++; if (mem_addr !== 8'h00) begin n_err++; $display("FAIL reset_addr got %h exp 00", mem_addr); end
    n_cmp++; if ({s, bad_instr, halted} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b exp 000", {s, bad_instr, halted}); end
    n_cmp++; if (sximm8 !== 16'h0000 || opcode !== 3'b000) begin n_err++; $display("FAIL reset_ir got imm8 %h opc %b exp 0000 000", sximm8, opcode); end
  endtask

  task automatic test_fetch_start();
    do_reset();
    mem_ack = 1'b1; mem_rdata = 16'hD2A5;
    step();
    mem_ack = 1'b0;
    n_cmp++; if (s !== 1'b1) begin n_err++; $display("FAIL start_s got %b exp 1", s); end
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL start_mem_req got %b exp 0", mem_req); end
    n_cmp++; if (pc !== 8'h01) begin n_err++; $display("FAIL start_pc got %h exp 01", pc); end
    n_cmp++; if (opcode !== 3'b110 || op !== 2'b10 || alu_op !== 2'b10) begin n_err++; $display("FAIL start_fields got %b %b %b exp 110 10 10", opcode, op, alu_op); end
    n_cmp++; if (sximm8 !== 16'hFFA5 || sximm5 !== 16'h0005 || shift !== 2'b00) begin n_err++; $display("FAIL start_imm got %h %h %b exp FFA5 0005 00", sximm8, sximm5, shift); end
    step();
    n_cmp++; if (s !== 1'b0 || mem_req !== 1'b0) begin n_err++; $display("FAIL wait_s_req got %b%b exp 00", s, mem_req); end
    step();
    n_cmp++; if (mem_req !== 1'b0 || sximm8 !== 16'hFFA5) begin n_err++; $display("FAIL wait_hold got req %b imm %h exp 0 FFA5", mem_req, sximm8); end
    ctrl_done = 1'b1;
    step();
    ctrl_done = 1'b0;
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 8'h01) begin n_err++; $display("FAIL done_refetch got req %b addr %h exp 1 01", mem_req, mem_addr); end
  endtask

  task automatic test_delayed_ack();
    logic [2:0] nsel_v [4];
    logic [2:0] exp_num [4];
    nsel_v  = '{3'b001, 3'b010, 3'b100, 3'b011};
    exp_num = '{3'd4, 3'd7, 3'd3, 3'd0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 8'h00 || s !== 1'b0) begin n_err++; $display("FAIL delay_hold cyc %0d got req %b addr %h s %b exp 1 00 0", i, mem_req, mem_addr, s); end
    end
    mem_ack = 1'b1; mem_rdata = 16'hA4E3;
    step();
    mem_ack = 1'b0;
    n_cmp++; if (s !== 1'b1) begin n_err++; $display("FAIL delay_s got %b exp 1", s); end
    step();
    for (int i = 0; i < 4; i++) begin
      nsel = nsel_v[i];
      #1;
      n_cmp++; if (readnum !== exp_num[i] || writenum !== exp_num[i]) begin n_err++; $display("FAIL regsel nsel %b got %0d/%0d exp %0d", nsel, readnum, writenum, exp_num[i]); end
    end
    ctrl_done = 1'b1;
    step();
    ctrl_done = 1'b0;
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 8'h01) begin n_err++; $display("FAIL regsel_refetch got req %b addr %h exp 1 01", mem_req, mem_addr); end
  endtask

  task automatic test_bad_instr();
    do_reset();
    mem_ack = 1'b1; mem_rdata = 16'h0000;
    step();
    mem_ack = 1'b0;
    n_cmp++; if (bad_instr !== 1'b1 || s !== 1'b0) begin n_err++; $display("FAIL bad_pulse got bad %b s %b exp 1 0", bad_instr, s); end
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 8'h01) begin n_err++; $display("FAIL bad_next got req %b addr %h exp 1 01", mem_req, mem_addr); end
    step();
    n_cmp++; if (bad_instr !== 1'b0 || s !== 1'b0) begin n_err++; $display("FAIL bad_clear got bad %b s %b exp 0 0", bad_instr, s); end
  endtask

  // A bad fetch and a valid fetch accepted on back-to-back edges.
  // ctrl_done is held high in SSTART to show it is ignored outside SWAIT.
  task automatic test_back_to_back();
    do_reset();
    mem_ack = 1'b1; mem_rdata = 16'h8000;
    step();
    mem_rdata = 16'hB0F8;
    step();
    mem_ack = 1'b0;
    n_cmp++; if (s !== 1'b1 || bad_instr !== 1'b0 || pc !== 8'h02) begin n_err++; $display("FAIL b2b_start got s %b bad %b pc %h exp 1 0 02", s, bad_instr, pc); end
    n_cmp++; if (sximm5 !== 16'hFFF8 || shift !== 2'b11 || opcode !== 3'b101 || op !== 2'b10) begin n_err++; $display("FAIL b2b_fields got %h %b %b %b exp FFF8 11 101 10", sximm5, shift, opcode, op); end
    ctrl_done = 1'b1;
    step();
    n_cmp++; if (mem_req !== 1'b0 || s !== 1'b0) begin n_err++; $display("FAIL done_in_start got req %b s %b exp 0 0", mem_req, s); end
    step();
    ctrl_done = 1'b0;
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 8'h02) begin n_err++; $display("FAIL b2b_refetch got req %b addr %h exp 1 02", mem_req, mem_addr); end
  endtask

  task automatic test_pc_wrap();
    reset2 = 1'b1;
    step();
    reset2 = 1'b0;
    n_cmp++; if (pc2 !== 8'hFF || mem_addr2 !== 8'hFF) begin n_err++; $display("FAIL wrap_reset got pc %h addr %h exp FF FF", pc2, mem_addr2); end
    mem_ack2 = 1'b1; mem_rdata2 = 16'h0000;
    step();
    mem_ack2 = 1'b0;
    n_cmp++; if (pc2 !== 8'h00 || mem_addr2 !== 8'h00) begin n_err++; $display("FAIL wrap_pc got pc %h addr %h exp 00 00", pc2, mem_addr2); end
  endtask

  task automatic test_reset_override();
    do_reset();
    mem_ack = 1'b1; mem_rdata = 16'hA4E3;
    step();
    mem_ack = 1'b0;
    step();
    reset = 1'b1; ctrl_done = 1'b1;
    step();
    reset = 1'b0; ctrl_done = 1'b0;
    n_cmp++; if (mem_req !== 1'b1 || pc !== 8'h00 || s !== 1'b0) begin n_err++; $display("FAIL rst_wait got req %b pc %h s %b exp 1 00 0", mem_req, pc, s); end
    n_cmp++; if (sximm8 !== 16'h0000 || opcode !== 3'b000) begin n_err++; $display("FAIL rst_wait_ir got %h %b exp 0000 000", sximm8, opcode); end
    // A fetch that arrives in the same cycle as reset is discarded.
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hD2A5;
    step();
    reset = 1'b0; mem_ack = 1'b0;
    n_cmp++; if (pc !== 8'h00 || s !== 1'b0 || opcode !== 3'b000 || mem_req !== 1'b1) begin n_err++; $display("FAIL rst_ack got pc %h s %b opc %b req %b exp 00 0 000 1", pc, s, opcode, mem_req); end
  endtask

  task automatic test_opcode_111();
    do_reset();
    mem_ack = 1'b1; mem_rdata = 16'hE000;
    step();
`ifdef INSTR_FETCH_HALT_EN
    // mem_ack stays high to show that it is ignored while halted.
    for (int i = 0; i < 20; i++) begin
      n_cmp++; if (halted !== 1'b1 || mem_req !== 1'b0 || s !== 1'b0 || pc !== 8'h01) begin n_err++; $display("FAIL halt cyc %0d got h %b req %b s %b pc %h exp 1 0 0 01", i, halted, mem_req, s, pc); end
      step();
    end
    mem_ack = 1'b0;
    do_reset();
    n_cmp++; if (halted !== 1'b0 || mem_req !== 1'b1) begin n_err++; $display("FAIL halt_exit got h %b req %b exp 0 1", halted, mem_req); end
`else
    mem_ack = 1'b0;
    n_cmp++; if (bad_instr !== 1'b1 || halted !== 1'b0 || s !== 1'b0) begin n_err++; $display("FAIL op111 got bad %b h %b s %b exp 1 0 0", bad_instr, halted, s); end
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 8'h01) begin n_err++; $display("FAIL op111_next got req %b addr %h exp 1 01", mem_req, mem_addr); end
    step();
    n_cmp++; if (bad_instr !== 1'b0) begin n_err++; $display("FAIL op111_clear got %b exp 0", bad_instr); end
`endif
  endtask

  initial begin
    reset = 1'b1; mem_ack = 1'b0; ctrl_done = 1'b0; mem_rdata = '0; nsel = 3'b001;
    reset2 = 1'b1; mem_ack2 = 1'b0; mem_rdata2 = '0;
    test_reset();
    test_fetch_start();
    test_delayed_ack();
    test_bad_instr();
    test_back_to_back();
    test_pc_wrap();
    test_reset_override();
    test_opcode_111();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_decode.md
INSTR_FETCH_DECODE -- requirements
Module: instr_fetch_decode

Interface
REQ-001 Parameter PC_W, default 8: program counter and memory address width.
REQ-002 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 mem_req  out  1  instruction read request, held until accepted.
REQ-006 mem_addr  out  PC_W  read address, equal to PC while mem_req is high.
REQ-007 mem_ack  in  1  read accepted; mem_rdata is valid in the same cycle.
REQ-008 mem_rdata  in  16  instruction word.
REQ-009 s  out  1  one-cycle start pulse to the controller FSM.
REQ-010 ctrl_done  in  1  controller has returned to its reset state; instruction retired.
REQ-011 opcode  out  3  IR[15:13].  op  out  2  IR[12:11].  ALUop  out  2  IR[12:11].  shift  out  2  IR[4:3].
REQ-012 nsel  in  3  one-hot register select: 001 Rn, 010 Rd, 100 Rm.
REQ-013 readnum, writenum  out  3 each  both equal the nsel-selected field.
REQ-014 sximm8  out  16  IR[7:0] sign-extended.  sximm5  out  16  IR[4:0] sign-extended.
REQ-015 bad_instr  out  1  one-cycle pulse when an undecodable instruction is skipped.
REQ-016 halted  out  1  high while in SHALT (0 when HALT_EN undefined).
REQ-017 pc  out  PC_W  current PC.

Function
REQ-018 States SFETCH, SSTART, SWAIT, SHALT; registered state, Moore outputs.
REQ-019 SFETCH: mem_req=1, mem_addr=pc; without mem_ack, stay.
REQ-020 SFETCH with mem_ack: IR<=mem_rdata, pc<=pc+1 mod 2^PC_W (all-ones wraps to 0), next state chosen from mem_rdata[15:13].
REQ-021 Fetched opcode 101 or 110 -> SSTART; SSTART asserts s for exactly one cycle, then SWAIT.
REQ-022 Fetched opcode in {000..100} (and 111 when HALT_EN undefined) -> stay SFETCH, bad_instr=1 next cycle for one cycle, s never asserted.
REQ-023 SWAIT: hold IR and pc; on ctrl_done -> SFETCH next cycle. ctrl_done outside SWAIT is ignored.
REQ-024 IR changes only on an accepted fetch; decode outputs are stable from SSTART through SWAIT.
REQ-025 nsel not one-hot -> readnum=writenum=000.
REQ-026 Fetch-to-s latency: s high in the cycle after the mem_ack edge; mem_req low in SSTART, SWAIT, SHALT.

Reset
REQ-027 Reset sampled high: state<=SFETCH, pc<=RESET_PC, IR<=0, s=0, bad_instr=0, halted=0 from the following cycle; mem_req=1 from the following cycle.
REQ-028 Reset overrides everything, including mem_ack or ctrl_done in the same cycle; an in-flight fetch is discarded.

Configuration
REQ-029 Macro INSTR_FETCH_HALT_EN: defined -> fetched opcode 111 enters SHALT (halted=1, mem_req=0, s=0, pc frozen at halt address+1) until reset; undefined -> SHALT unreachable, 111 handled per REQ-022, halted tied 0.

Verification
REQ-030 Reset, mem_ack on first req with 16'hD2A5 -> IR=D2A5, opcode=110, op=10, s pulse 1 cycle, pc=1, sximm8=16'hFFA5.
REQ-031 mem_ack delayed 5 cycles -> mem_req and mem_addr=0 held all 5 cycles, no s until ack.
REQ-032 In SWAIT, nsel=001/010/100/011 with IR=16'hA4E3 -> readnum=4/7/3/0; ctrl_done -> mem_req next cycle with mem_addr=1.
REQ-033 Fetch 16'h0000 -> bad_instr 1 cycle, s stays 0, next fetch at addr 1; RESET_PC=8'hFF fetch -> pc wraps to 0.
REQ-034 Reset asserted in SWAIT with ctrl_done=1 -> SFETCH, pc=RESET_PC, IR=0.
REQ-035 With INSTR_FETCH_HALT_EN, fetch 16'hE000 -> halted=1, mem_req=0 for 20 cycles; without it, bad_instr pulse and fetch continues.
